// File: rtl/int_sched_pkg.sv
// Shared types and constants for the interrupter scheduler: state encoding,
// configuration widths, default timing parameters and period arithmetic.
package int_sched_pkg;

    localparam int CONF_PAR       = 8;
    localparam int PER_W          = 9;
    localparam int DEF_TICK_DIV   = 500;
    localparam int DEF_LOCK_TICKS = 64;

    typedef enum logic [3:0] {
        S_IDLE = 4'b0001,
        S_ON   = 4'b0010,
        S_OFF  = 4'b0100,
        S_LOCK = 4'b1000
    } state_e;

    // Period length in ticks: a rate code of 255 gives the shortest period (1).
    function automatic logic [PER_W-1:0] calc_per(input logic [CONF_PAR-1:0] freq);
        return 9'd256 - {1'b0, freq};
    endfunction

    // On-time is clamped so every period keeps at least one off tick.
    function automatic logic [PER_W-1:0] calc_on(input logic [CONF_PAR-1:0] freq,
                                                 input logic [CONF_PAR-1:0] pw);
        logic [PER_W-1:0] per_m1;
        per_m1 = calc_per(freq) - 9'd1;
        if ({1'b0, pw} < per_m1) begin
            return {1'b0, pw};
        end
        return per_m1;
    endfunction

endpackage

// File: rtl/int_sched_tick_gen.sv
// Free-running prescaler: emits a one-clk tick at the terminal count of
// every TICK_DIV clocks, independent of scheduler state.
module int_sched_tick_gen
    import int_sched_pkg::*;
#(
    parameter int TICK_DIV = DEF_TICK_DIV
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = $clog2(TICK_DIV);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = (cnt_q == CW'(TICK_DIV - 1));
        cnt_d = tick ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/int_sched.sv
// Interrupter burst scheduler: periodic on/off gate timing in ticks, with
// synchronized over-current trips forcing a timed lockout.
module int_sched
    import int_sched_pkg::*;
#(
    parameter int TICK_DIV   = DEF_TICK_DIV,
    parameter int LOCK_TICKS = DEF_LOCK_TICKS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                conf_vld,
    input  logic [CONF_PAR-1:0] conf_int_freq,
    input  logic [CONF_PAR-1:0] conf_int_pw,
    input  logic                ocd,
    output logic                int_out,
    output logic                lock,
    output logic [7:0]          ocd_cnt,
    output state_e              state_dbg
);

    logic tick;

    int_sched_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    state_e              state_q, state_d;
    logic [PER_W-1:0]    cnt_q, cnt_d;
    logic [7:0]          lock_cnt_q, lock_cnt_d;
    logic [CONF_PAR-1:0] pend_freq_q, pend_freq_d, pend_pw_q, pend_pw_d;
    logic [CONF_PAR-1:0] act_freq_q, act_freq_d, act_pw_q, act_pw_d;
    logic                int_out_q, int_out_d, lock_q, lock_d;
    logic [7:0]          ocd_cnt_q, ocd_cnt_d;
    logic [2:0]          ocd_sync_q, ocd_sync_d;

    logic                trip, start;
    logic [PER_W-1:0]    act_per, act_on, nxt_on, cnt_inc;
    logic [7:0]          lock_inc;

    always_comb begin
        ocd_sync_d  = {ocd_sync_q[1:0], ocd};
        trip        = ocd_sync_q[1] & ~ocd_sync_q[2];
        act_per     = calc_per(act_freq_q);
        act_on      = calc_on(act_freq_q, act_pw_q);
        nxt_on      = calc_on(pend_freq_q, pend_pw_q);
        cnt_inc     = cnt_q + 1'b1;
        lock_inc    = lock_cnt_q + 1'b1;

        state_d     = state_q;
        cnt_d       = cnt_q;
        lock_cnt_d  = lock_cnt_q;
        act_freq_d  = act_freq_q;
        act_pw_d    = act_pw_q;
        ocd_cnt_d   = ocd_cnt_q;
        pend_freq_d = conf_vld ? conf_int_freq : pend_freq_q;
        pend_pw_d   = conf_vld ? conf_int_pw   : pend_pw_q;
        start       = 1'b0;

        // A trip outranks enable and every tick-driven transition.
        if (trip && state_q != S_LOCK) begin
            state_d    = S_LOCK;
            lock_cnt_d = '0;
            if (ocd_cnt_q != 8'hFF) begin
                ocd_cnt_d = ocd_cnt_q + 1'b1;
            end
        end else if (!en && (state_q == S_ON || state_q == S_OFF)) begin
            state_d = S_IDLE;
        end else if (tick) begin
            case (state_q)
                S_IDLE: start = en;
                S_ON: begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == act_on) begin
                        state_d = S_OFF;
                    end
                end
                S_OFF: begin
                    if (cnt_inc == act_per) begin
                        start = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                S_LOCK: begin
                    lock_cnt_d = lock_inc;
                    if (lock_inc == 8'(LOCK_TICKS)) begin
                        if (en) begin
                            start = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        // Period start takes the pending values as they were before this clk.
        if (start) begin
            act_freq_d = pend_freq_q;
            act_pw_d   = pend_pw_q;
            cnt_d      = '0;
            state_d    = (nxt_on != '0) ? S_ON : S_OFF;
        end

        int_out_d = (state_d == S_ON);
        lock_d    = (state_d == S_LOCK);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            lock_cnt_q  <= '0;
            pend_freq_q <= '0;
            pend_pw_q   <= '0;
            act_freq_q  <= '0;
            act_pw_q    <= '0;
            int_out_q   <= 1'b0;
            lock_q      <= 1'b0;
            ocd_cnt_q   <= '0;
            ocd_sync_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lock_cnt_q  <= lock_cnt_d;
            pend_freq_q <= pend_freq_d;
            pend_pw_q   <= pend_pw_d;
            act_freq_q  <= act_freq_d;
            act_pw_q    <= act_pw_d;
            int_out_q   <= int_out_d;
            lock_q      <= lock_d;
            ocd_cnt_q   <= ocd_cnt_d;
            ocd_sync_q  <= ocd_sync_d;
        end
    end

    assign int_out   = int_out_q;
    assign lock      = lock_q;
    assign ocd_cnt   = ocd_cnt_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_int_sched.sv
// Bench for int_sched: tick-level behavioural model compared every cycle,
// plus directed scenarios with hand-computed burst, lockout and latency values.
module tb_int_sched;
    import int_sched_pkg::*;

    localparam int TD = 4;
    localparam int LT = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       conf_vld = 1'b0;
    logic [7:0] conf_int_freq = '0;
    logic [7:0] conf_int_pw = '0;
    logic       ocd = 1'b0;
    logic       int_out, lock;
    logic [7:0] ocd_cnt;
    state_e     state_dbg;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en = 1'b1;

    int_sched #(.TICK_DIV(TD), .LOCK_TICKS(LT)) dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .conf_vld      (conf_vld),
        .conf_int_freq (conf_int_freq),
        .conf_int_pw   (conf_int_pw),
        .ocd           (ocd),
        .int_out       (int_out),
        .lock          (lock),
        .ocd_cnt       (ocd_cnt),
        .state_dbg     (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_rng(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d..%0d (t=%0t)", name, act, lo, hi, $time);
        end
    endtask

    // Model: mode 0 idle, 1 running a period, 2 lockout; on/off is derived
    // from the position inside the period rather than tracked as a state.
    int m_mode = 0, m_per = 0, m_on = 0, m_pos = 0, m_lock_left = 0;
    int m_presc = 0, m_ocd = 0, m_pf = 0, m_ppw = 0;
    bit [2:0] m_sync = '0;
    bit m_tk, m_trp, m_st;

    always @(posedge clk) begin
        if (rst) begin
            m_mode = 0; m_per = 0; m_on = 0; m_pos = 0; m_lock_left = 0;
            m_presc = 0; m_ocd = 0; m_pf = 0; m_ppw = 0; m_sync = '0;
        end else begin
            m_tk  = (m_presc == TD - 1);
            m_trp = m_sync[1] && !m_sync[2];
            m_st  = 1'b0;
            if (m_trp && m_mode != 2) begin
                m_mode = 2;
                m_lock_left = LT;
                if (m_ocd < 255) m_ocd++;
            end else if (m_mode == 1 && !en) begin
                m_mode = 0;
            end else if (m_tk) begin
                if (m_mode == 0) begin
                    m_st = en;
                end else if (m_mode == 1) begin
                    m_pos++;
                    m_st = (m_pos == m_per);
                end else begin
                    m_lock_left--;
                    if (m_lock_left == 0) begin
                        if (en) m_st = 1'b1;
                        else m_mode = 0;
                    end
                end
            end
            if (m_st) begin
                m_per  = 256 - m_pf;
                m_on   = (m_ppw < m_per - 1) ? m_ppw : m_per - 1;
                m_pos  = 0;
                m_mode = 1;
            end
            if (conf_vld) begin
                m_pf  = conf_int_freq;
                m_ppw = conf_int_pw;
            end
            m_sync  = {m_sync[1:0], ocd};
            m_presc = (m_presc + 1) % TD;
        end
    end

    function automatic int exp_state();
        if (m_mode == 0) return int'(S_IDLE);
        if (m_mode == 2) return int'(S_LOCK);
        return (m_pos < m_on) ? int'(S_ON) : int'(S_OFF);
    endfunction

    always @(negedge clk) begin
        if (cmp_en) begin
            if (rst) begin
                check_eq("rst_int_out", int'(int_out), 0);
                check_eq("rst_lock", int'(lock), 0);
                check_eq("rst_ocd_cnt", int'(ocd_cnt), 0);
            end else begin
                check_eq("model_int_out", int'(int_out), (m_mode == 1 && m_pos < m_on) ? 1 : 0);
                check_eq("model_lock", int'(lock), (m_mode == 2) ? 1 : 0);
                check_eq("model_ocd_cnt", int'(ocd_cnt), m_ocd);
                check_eq("model_state", int'(state_dbg), exp_state());
            end
        end
    end

    // Caller is at a negedge; the strobe lasts exactly one clk.
    task automatic send_conf(input int f, input int pw);
        conf_int_freq = 8'(f);
        conf_int_pw   = 8'(pw);
        conf_vld      = 1'b1;
        @(negedge clk);
        conf_vld      = 1'b0;
    endtask

    // Measures one full burst: high clks, then low clks up to the next rise.
    // A nonzero conf_at injects a config strobe at that clk of the burst.
    task automatic measure_burst(input int conf_at, input int f, input int pw,
                                 output int hi, output int lo);
        int guard;
        guard = 0; hi = 0; lo = 0;
        while (int_out && guard < 3000) begin @(negedge clk); guard++; end
        while (!int_out && guard < 3000) begin @(negedge clk); guard++; end
        while (int_out && hi < 3000) begin
            hi++;
            if (hi == conf_at) begin
                conf_int_freq = 8'(f);
                conf_int_pw   = 8'(pw);
                conf_vld      = 1'b1;
            end else begin
                conf_vld = 1'b0;
            end
            @(negedge clk);
        end
        conf_vld = 1'b0;
        while (!int_out && lo < 3000) begin lo++; @(negedge clk); end
    endtask

    int hi, lo, n, lat, len;

    initial begin
        @(negedge clk);
        check_eq("reset_state", int'(state_dbg), int'(S_IDLE));
        check_eq("reset_int_out", int'(int_out), 0);
        check_eq("reset_ocd_cnt", int'(ocd_cnt), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // freq 246 -> period 10 ticks, pw 3 -> 12 clk high, 28 clk low
        send_conf(246, 3);
        en = 1'b1;
        measure_burst(0, 0, 0, hi, lo);
        check_eq("basic_hi", hi, 12);
        check_eq("basic_lo", lo, 28);
        measure_burst(0, 0, 0, hi, lo);
        check_eq("basic_hi2", hi, 12);
        check_eq("basic_lo2", lo, 28);

        // mid-burst config leaves this period alone; the next is 20 ticks, 5 on
        measure_burst(6, 236, 5, hi, lo);
        check_eq("midconf_cur_hi", hi, 12);
        check_eq("midconf_cur_lo", lo, 28);
        measure_burst(0, 0, 0, hi, lo);
        check_eq("midconf_next_hi", hi, 20);
        check_eq("midconf_next_lo", lo, 60);

        // pw 20 clamps to per-1 = 9 ticks on, 1 tick off
        send_conf(246, 20);
        measure_burst(0, 0, 0, hi, lo);
        measure_burst(0, 0, 0, hi, lo);
        check_eq("clamp_hi", hi, 36);
        check_eq("clamp_lo", lo, 4);

        // pw 0: period runs fully off
        send_conf(246, 0);
        repeat (120) @(negedge clk);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            if (int_out) n++;
            @(negedge clk);
        end
        check_eq("pw0_high_clks", n, 0);
        check_eq("pw0_state", int'(state_dbg), int'(S_OFF));

        // OCD trip during ON; a second edge inside lockout is ignored
        send_conf(246, 3);
        n = 0;
        while (!int_out && n < 200) begin @(negedge clk); n++; end
        check_eq("ocd_burst_seen", int'(int_out), 1);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #3 ocd = 1'b1;
        lat = 0;
        do begin
            @(posedge clk);
            #1 lat++;
        end while (int_out && lat < 10);
        check_rng("ocd_latency_clks", lat, 1, 3);
        @(negedge clk);
        check_eq("ocd_lock_high", int'(lock), 1);
        check_eq("ocd_cnt_one", int'(ocd_cnt), 1);
        len = 0;
        while (lock && len < 100) begin
            len++;
            if (len == 2) ocd = 1'b0;
            if (len == 10) ocd = 1'b1;
            if (len == 14) ocd = 1'b0;
            @(negedge clk);
        end
        check_rng("lockout_clks", len, (LT - 1) * TD + 1, LT * TD);
        check_eq("ocd_cnt_after_relock", int'(ocd_cnt), 1);

        // many trips saturate the counter at 255
        for (int i = 0; i < 256; i++) begin
            ocd = 1'b1;
            repeat (2) @(negedge clk);
            ocd = 1'b0;
            n = 0;
            while (!lock && n < 10) begin @(negedge clk); n++; end
            n = 0;
            while (lock && n < 60) begin @(negedge clk); n++; end
        end
        check_eq("ocd_cnt_saturated", int'(ocd_cnt), 255);

        // asynchronous reset in the middle of a burst
        n = 0;
        while (!int_out && n < 200) begin @(negedge clk); n++; end
        check_eq("rst_burst_seen", int'(int_out), 1);
        @(posedge clk);
        #2 rst = 1'b1;
        en = 1'b0;
        #1;
        check_eq("async_rst_int_out", int'(int_out), 0);
        check_eq("async_rst_ocd_cnt", int'(ocd_cnt), 0);
        check_eq("async_rst_state", int'(state_dbg), int'(S_IDLE));
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check_eq("post_rst_idle", int'(state_dbg), int'(S_IDLE));
        // cleared pending regs give no burst even with en high
        en = 1'b1;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (int_out) n++;
            @(negedge clk);
        end
        check_eq("post_rst_no_conf_high", n, 0);
        en = 1'b0;
        @(negedge clk);
        send_conf(246, 3);
        en = 1'b1;
        n = 0;
        while (!int_out && n < 20) begin @(negedge clk); n++; end
        check_rng("post_rst_restart_clks", n, 1, TD + 1);

        // dropping en in ON ends the burst on the next clk
        repeat (3) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        check_eq("en_drop_int_out", int'(int_out), 0);
        check_eq("en_drop_state", int'(state_dbg), int'(S_IDLE));
        repeat (5) @(negedge clk);
        en = 1'b1;
        n = 0;
        while (!int_out && n < 20) begin @(negedge clk); n++; end
        check_rng("en_resume_clks", n, 1, TD);
        measure_burst(0, 0, 0, hi, lo);
        check_eq("en_resume_hi", hi, 12);

        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL global_timeout: got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/int_sched.md
INT_SCHED -- requirements
Module: int_sched

Interface
REQ-001 Parameter TICK_DIV, default 500, clk cycles per scheduler tick (10 us at 50 MHz); legal range 2..65535.
REQ-002 Parameter LOCK_TICKS, default 64, ticks of forced off-time after an OCD trip; legal range 1..255.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 en  input  1  global run enable, synchronous level.
REQ-006 conf_vld  input  1  one-clk strobe: conf_int_freq/conf_int_pw valid (from UART packet decoder).
REQ-007 conf_int_freq  input  8  interrupter rate code; period_ticks = 256 - code.
REQ-008 conf_int_pw  input  8  requested on-time in ticks.
REQ-009 ocd  input  1  over-current detect, asynchronous to clk, active-high.
REQ-010 int_out  output  1  interrupter gate to bridge driver, high = burst active.
REQ-011 lock  output  1  high while in LOCKOUT.
REQ-012 ocd_cnt  output  8  saturating count of OCD trips.

Function
REQ-013 Tick: prescaler counts 0..TICK_DIV-1; tick is one-clk pulse at terminal count; prescaler runs continuously whenever rst is low, regardless of state.
REQ-014 Config: conf_vld loads pending regs (pend_freq, pend_pw) on that clk; pending copied to active regs only in IDLE or on the clk a new period starts (OFF->ON transition); mid-period conf_vld never alters the running period.
REQ-015 Derived: per = 256 - act_freq (9-bit, range 1..256); on = min(act_pw, per - 1); pw = 0 or per = 1 gives on = 0 (period runs fully off).
REQ-016 States: IDLE, ON, OFF, LOCKOUT; encoding one-hot.
REQ-017 IDLE: int_out = 0; on en = 1 and tick: load active regs, clear period counter, go ON if on > 0 else OFF.
REQ-018 ON: int_out = 1; period counter increments per tick; at count = on go OFF.
REQ-019 OFF: int_out = 0; at count = per go ON (or stay OFF if new on = 0), reloading active regs and clearing counter on that clk.
REQ-020 OCD path: ocd passed through 2-FF synchronizer; synchronized rising edge in any state except LOCKOUT -> LOCKOUT, int_out registered low; int_out low no later than 3 clk after ocd rises.
REQ-021 LOCKOUT: int_out = 0, lock = 1; counts LOCK_TICKS ticks; then IDLE if en = 0, else restarts a fresh period (as in REQ-017 with the same tick).
REQ-022 ocd_cnt increments by 1 per accepted trip, saturates at 255; OCD edges during LOCKOUT neither counted nor extend lockout.
REQ-023 en = 0 in ON/OFF -> IDLE on next clk, int_out low that clk; en = 0 in LOCKOUT does not shorten lockout.
REQ-024 Simultaneous: OCD edge beats end-of-on/end-of-period transitions; conf_vld on a period-start clk: the new values land in pending only, the active load uses previous pending.
REQ-025 int_out is a registered output, glitch-free; never high outside ON.

Reset
REQ-026 rst asserted: state = IDLE, int_out = 0, lock = 0, ocd_cnt = 0, prescaler/period/lockout counters = 0, synchronizer FFs = 0, pending and active regs = 0; takes effect immediately without clk.
REQ-027 rst mid-burst forces int_out low asynchronously; after release, operation resumes only from IDLE at the next tick with en = 1 (pending regs must be reloaded via conf_vld).

Structure
REQ-028 Shared package holds: state enum type, CONF_PAR width constant (8), default TICK_DIV and LOCK_TICKS, period-width constant (9).
REQ-029 One sub-module: tick_gen (prescaler, parameter TICK_DIV, outputs tick); synchronizer and FSM stay inline.

Verification (bench uses TICK_DIV = 4, LOCK_TICKS = 8)
REQ-030 conf freq=246, pw=3, en=1 -> int_out high 3 ticks (12 clk), low 7 ticks, period 10 ticks repeating.
REQ-031 pw=20 with freq=246 -> on clamped to 9 ticks, off 1 tick; pw=0 -> int_out stays 0, state cycles OFF.
REQ-032 conf_vld (freq=236, pw=5) during tick 2 of ON -> current period unchanged at 10/3, following period 20 ticks with 5 on.
REQ-033 ocd pulse in ON -> int_out low within 3 clk, lock high for 8 ticks, ocd_cnt = 1; second ocd during lockout -> ocd_cnt stays 1, lockout length unchanged.
REQ-034 256 OCD trips -> ocd_cnt = 255 (saturated); rst asserted mid-ON -> int_out 0 same clk, ocd_cnt 0, restarts only after new conf_vld and tick.
REQ-035 en dropped during ON -> int_out 0 next clk, IDLE; en re-raised -> burst resumes on the next tick.
